// File: rtl/cla_pipe_adder.sv
// Pipelined block carry-lookahead adder/subtractor with a valid/ready handshake and status flags.
// Optional signed saturation in the last stage is enabled by defining CLA_SAT_EN.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / BLK;
  localparam int MSB = WIDTH - 1;

  if ((WIDTH % STAGES) != 0 || ((WIDTH / STAGES) % BLK) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must split into STAGES segments of whole BLK-bit groups");
  end

  // Carry into every bit of a BLK-bit group, full lookahead from c.
  function automatic logic [BLK:0] f_blk_carry(input logic [BLK-1:0] p,
                                               input logic [BLK-1:0] g,
                                               input logic           c);
    logic [BLK:0] w_cv;
    logic         w_t;
    for (int j = 0; j <= BLK; j++) begin
      w_t = c;
      for (int i = 0; i < j; i++) w_t = w_t & p[i];
      w_cv[j] = w_t;
      for (int i = 0; i < j; i++) begin
        w_t = g[i];
        for (int k = i + 1; k < j; k++) w_t = w_t & p[k];
        w_cv[j] = w_cv[j] | w_t;
      end
    end
    return w_cv;
  endfunction

  function automatic logic [NG:0] f_grp_carry(input logic [NG-1:0] p,
                                              input logic [NG-1:0] g,
                                              input logic          c);
    logic [NG:0] w_cv;
    logic        w_t;
    for (int j = 0; j <= NG; j++) begin
      w_t = c;
      for (int i = 0; i < j; i++) w_t = w_t & p[i];
      w_cv[j] = w_t;
      for (int i = 0; i < j; i++) begin
        w_t = g[i];
        for (int k = i + 1; k < j; k++) w_t = w_t & p[k];
        w_cv[j] = w_cv[j] | w_t;
      end
    end
    return w_cv;
  endfunction

  // One segment: group P/G, second-level lookahead across groups, then bit sums. Returns {cout, sum}.
  function automatic logic [SEG:0] f_seg(input logic [SEG-1:0] p,
                                         input logic [SEG-1:0] g,
                                         input logic           c);
    logic [NG-1:0]  w_gp;
    logic [NG-1:0]  w_gg;
    logic [NG:0]    w_gc;
    logic [BLK:0]   w_bc;
    logic [SEG-1:0] w_s;
    for (int j = 0; j < NG; j++) begin
      w_bc    = f_blk_carry(p[j*BLK +: BLK], g[j*BLK +: BLK], 1'b0);
      w_gg[j] = w_bc[BLK];
      w_gp[j] = &p[j*BLK +: BLK];
    end
    w_gc = f_grp_carry(w_gp, w_gg, c);
    for (int j = 0; j < NG; j++) begin
      w_bc                = f_blk_carry(p[j*BLK +: BLK], g[j*BLK +: BLK], w_gc[j]);
      w_s[j*BLK +: BLK]   = p[j*BLK +: BLK] ^ w_bc[BLK-1:0];
    end
    return {w_gc[NG], w_s};
  endfunction

  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_stall;
  logic [WIDTH-1:0] w_beff;
  logic [WIDTH-1:0] w_in_p;
  logic [WIDTH-1:0] w_in_g;
  logic             w_c0;
  logic             w_sat_in;

  // A stall freezes the whole pipe, so bubbles keep their slots.
  assign w_stall  = r_out_vld && !out_ready;
  assign in_ready = !w_stall;

  assign w_beff = sub ? ~b : b;
  assign w_c0   = sub ? 1'b1 : cin;
  assign w_in_p = a ^ w_beff;
  assign w_in_g = a & w_beff;

`ifdef CLA_SAT_EN
  assign w_sat_in = sat;
`else
  logic w_sat_unused;
  assign w_sat_in     = 1'b0;
  assign w_sat_unused = sat;
`endif

  for (genvar s = 0; s < STAGES - 1; s++) begin : g_st
    localparam int LO = s * SEG;
    localparam int UW = WIDTH - LO;

    logic [UW-1:0]     w_p;
    logic [UW-1:0]     w_g;
    logic [LO+SEG-1:0] w_done;
    logic              w_c;
    logic              w_vld;
    logic              w_sat;
    logic              w_amsb;
    logic              w_bmsb;
    logic [SEG:0]      w_seg;

    logic [LO+SEG-1:0] r_done;
    logic [UW-SEG-1:0] r_p;
    logic [UW-SEG-1:0] r_g;
    logic              r_c;
    logic              r_vld;
    logic              r_sat;
    logic              r_amsb;
    logic              r_bmsb;

    if (s == 0) begin : g_src
      assign w_p    = w_in_p;
      assign w_g    = w_in_g;
      assign w_c    = w_c0;
      assign w_vld  = in_valid;
      assign w_sat  = w_sat_in;
      assign w_amsb = a[MSB];
      assign w_bmsb = w_beff[MSB];
      assign w_done = w_seg[SEG-1:0];
    end else begin : g_src
      assign w_p    = g_st[s-1].r_p;
      assign w_g    = g_st[s-1].r_g;
      assign w_c    = g_st[s-1].r_c;
      assign w_vld  = g_st[s-1].r_vld;
      assign w_sat  = g_st[s-1].r_sat;
      assign w_amsb = g_st[s-1].r_amsb;
      assign w_bmsb = g_st[s-1].r_bmsb;
      assign w_done = {w_seg[SEG-1:0], g_st[s-1].r_done};
    end

    assign w_seg = f_seg(w_p[SEG-1:0], w_g[SEG-1:0], w_c);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_done <= '0;
        r_p    <= '0;
        r_g    <= '0;
        r_c    <= 1'b0;
        r_sat  <= 1'b0;
        r_amsb <= 1'b0;
        r_bmsb <= 1'b0;
      end else if (!w_stall) begin
        r_vld <= w_vld;
        if (w_vld) begin
          r_done <= w_done;
          r_p    <= w_p[UW-1:SEG];
          r_g    <= w_g[UW-1:SEG];
          r_c    <= w_seg[SEG];
          r_sat  <= w_sat;
          r_amsb <= w_amsb;
          r_bmsb <= w_bmsb;
        end
      end
    end
  end

  logic [SEG-1:0]   w_fp;
  logic [SEG-1:0]   w_fg;
  logic             w_fc;
  logic             w_fvld;
  logic             w_fsat;
  logic             w_famsb;
  logic             w_fbmsb;
  logic [SEG:0]     w_fseg;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  if (STAGES == 1) begin : g_fsrc
    assign w_fp    = w_in_p;
    assign w_fg    = w_in_g;
    assign w_fc    = w_c0;
    assign w_fvld  = in_valid;
    assign w_fsat  = w_sat_in;
    assign w_famsb = a[MSB];
    assign w_fbmsb = w_beff[MSB];
    assign w_raw   = w_fseg[SEG-1:0];
  end else begin : g_fsrc
    assign w_fp    = g_st[STAGES-2].r_p;
    assign w_fg    = g_st[STAGES-2].r_g;
    assign w_fc    = g_st[STAGES-2].r_c;
    assign w_fvld  = g_st[STAGES-2].r_vld;
    assign w_fsat  = g_st[STAGES-2].r_sat;
    assign w_famsb = g_st[STAGES-2].r_amsb;
    assign w_fbmsb = g_st[STAGES-2].r_bmsb;
    assign w_raw   = {w_fseg[SEG-1:0], g_st[STAGES-2].r_done};
  end

  assign w_fseg = f_seg(w_fp, w_fg, w_fc);

  // Overflow is judged on the wrapped sum; the clamp only replaces the result value.
  always_comb begin
    w_ovf = (w_famsb == w_fbmsb) && (w_raw[MSB] != w_famsb);
    w_res = w_raw;
    if (w_fsat && w_ovf) begin
      w_res = w_famsb ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else if (!w_stall) begin
      r_out_vld <= w_fvld;
      if (w_fvld) begin
        r_sum  <= w_res;
        r_cout <= w_fseg[SEG];
        r_ovf  <= w_ovf;
        r_zero <= (w_res == '0);
      end
    end
  end

  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=32, BLK=4, STAGES=2): vector table, stall, reset and random traffic.
module tb_cla_pipe_adder;
  localparam int W   = 32;
  localparam int STG = 2;
`ifdef CLA_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         sat = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  cla_pipe_adder #(.WIDTH(W), .BLK(4), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         sat;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           stamp;
    int           stalls;
  } exp_t;

  exp_t   q[$];
  exp_t   pend;
  exp_t   mon_e;
  vec_t   tbl[13];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     stalls = 0;
  bit     held = 1'b0;
  logic [W-1:0] h_sum;
  logic   h_cout, h_ovf, h_zero;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb, input logic st);
    exp_t         e;
    logic [W-1:0] be;
    logic [W:0]   r;
    be     = sb ? ~y : y;
    r      = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.cout = r[W];
    e.ovf  = (x[W-1] == be[W-1]) && (r[W-1] != x[W-1]);
    e.sum  = r[W-1:0];
    if (SAT_ON && st && e.ovf) e.sum = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.zero   = (e.sum == '0);
    e.stamp  = 0;
    e.stalls = 0;
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.sum = v.e_sum; e.cout = v.e_cout; e.ovf = v.e_ovf; e.zero = v.e_zero;
    e.stamp = 0; e.stalls = 0;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard: push on acceptance, pop and compare on consumption, watch held outputs during stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !out_ready) begin
        chk("in_ready_stalled", {31'b0, in_ready}, 32'd0);
        if (held) begin
          chk("hold_sum", sum, h_sum);
          chk("hold_flags", {29'b0, cout, ovf, zero}, {29'b0, h_cout, h_ovf, h_zero});
        end
        held = 1'b1;
        h_sum = sum; h_cout = cout; h_ovf = ovf; h_zero = zero;
        stalls++;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got sum %h with nothing outstanding", sum);
        end else begin
          mon_e = q.pop_front();
          chk("sum", sum, mon_e.sum);
          chk("cout", {31'b0, cout}, {31'b0, mon_e.cout});
          chk("ovf", {31'b0, ovf}, {31'b0, mon_e.ovf});
          chk("zero", {31'b0, zero}, {31'b0, mon_e.zero});
          chk("latency", cyc - mon_e.stamp, STG + stalls - mon_e.stalls);
        end
      end
      if (in_valid && in_ready) begin
        mon_e        = pend;
        mon_e.stamp  = cyc;
        mon_e.stalls = stalls;
        q.push_back(mon_e);
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb, input logic st, input exp_t e);
    bit acc;
    int n;
    a = x; b = y; cin = ci; sub = sb; sat = st; pend = e;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_outstanding", q.size(), 32'd0);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic send_rand();
    logic [W-1:0] x, y;
    logic         ci, sb, st;
    x  = $urandom;
    y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
    ci = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    st = 1'($urandom_range(0, 1));
    send(x, y, ci, sb, st, model(x, y, ci, sb, st));
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1,
                SAT_ON ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1,
                SAT_ON ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1,
                SAT_ON ? 32'h7FFF_FFFF : 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 1'b0, 32'h0000_0007, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Directed vectors, issued back to back.
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].sat, from_vec(tbl[i]));
    end
    drain();

    // Four beats back to back, then three cycles of backpressure with a fifth beat waiting.
    for (int i = 0; i < 4; i++) send_rand();
    fork
      send(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0,
           model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0));
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_cycles_seen", stalls, 32'd3);

    // Reset with two beats in flight: both must vanish.
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, model(32'h11, 32'h22, 1'b0, 1'b0, 1'b0));
    send(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0, 1'b0, model(32'h33, 32'h44, 1'b0, 1'b0, 1'b0));
    chk("inflight_out_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_sum", sum, 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    send(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 1'b0,
         '{32'h0000_0124, 1'b0, 1'b0, 1'b0, 0, 0});
    drain();

    // Random traffic with bubbles, operand noise while idle and random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand();
          if ($urandom_range(0, 3) == 0) begin
            a = $urandom; b = $urandom; sub = ~sub; sat = ~sat;
            @(posedge clk);
            #1;
          end
        end
      end
      begin
        repeat (80) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
